sys_bridge_n: RTL

Parametrised system bridge between the CPU memory stage and N memory-mapped slaves (DM, timers, UART, switches, tube, LEDs). It decodes each access against per-slave address windows and runs a request/ready handshake with wait-state support. It returns registered read data, or a coded bus error for unmapped, policy-violating or timed-out accesses. The CPU stalls on `pr_busy`; exception logic consumes `pr_err`/`pr_err_code`.

---
 rtl/bridge_pkg.sv | 19 +
 rtl/bridge_decode.sv | 30 +++
 rtl/sys_bridge_n.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared types and constants for the CPU-to-slave system bridge.
package bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_UNMAP   = 2'd1;
    localparam logic [1:0] ERR_POLICY  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Counter is sized for the largest legal TIMEOUT so one width serves every instance.
    localparam int unsigned TIMEOUT_MAX = 255;
    localparam int unsigned CNT_W       = $clog2(TIMEOUT_MAX + 1);

endpackage

// File: rtl/bridge_decode.sv
// Address window decoder: lowest-index hit wins; flags write-policy violations on the hit slave.
module bridge_decode #(
    parameter int unsigned             N_SLV     = 8,
    parameter logic [N_SLV*32-1:0]     SLV_BASE  = '0,
    parameter logic [N_SLV*32-1:0]     SLV_LIMIT = '1,
    parameter logic [N_SLV-1:0]        SLV_RO    = '0,
    parameter logic [N_SLV-1:0]        SLV_WORD  = '0
) (
    input  logic [31:0]      addr,
    input  logic [3:0]       byteen,
    output logic [N_SLV-1:0] sel,
    output logic             hit,
    output logic             policy_err
);

    always_comb begin
        sel        = '0;
        hit        = 1'b0;
        policy_err = 1'b0;
        for (int unsigned k = 0; k < N_SLV; k++) begin
            if (!hit && (addr >= SLV_BASE[32*k +: 32]) && (addr <= SLV_LIMIT[32*k +: 32])) begin
                hit    = 1'b1;
                sel[k] = 1'b1;
                if ((|byteen) && (SLV_RO[k] || (SLV_WORD[k] && (byteen != 4'b1111))))
                    policy_err = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sys_bridge_n.sv
// System bridge: decodes CPU accesses onto N memory-mapped slaves with
// request/ready handshake, wait-state timeout and coded bus errors.
module sys_bridge_n
    import bridge_pkg::*;
#(
    parameter int unsigned         N_SLV     = 8,
    parameter logic [N_SLV*32-1:0] SLV_BASE  = '0,
    parameter logic [N_SLV*32-1:0] SLV_LIMIT = '1,
    parameter logic [N_SLV-1:0]    SLV_RO    = '0,
    parameter logic [N_SLV-1:0]    SLV_WORD  = '0,
    parameter int unsigned         TIMEOUT   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pr_req,
    input  logic [31:0]           pr_addr,
    input  logic [31:0]           pr_wd,
    input  logic [3:0]            pr_byteen,
    input  logic                  pr_rd_en,
    output logic [31:0]           pr_rd,
    output logic                  pr_done,
    output logic                  pr_err,
    output logic [1:0]            pr_err_code,
    output logic                  pr_busy,
    output logic [31:0]           dev_addr,
    output logic [31:0]           dev_wd,
    output logic [N_SLV-1:0]      dev_sel,
    output logic [3:0]            dev_byteen,
    input  logic [N_SLV*32-1:0]   dev_rd,
    input  logic [N_SLV-1:0]      dev_ready
);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [1:0]         code_n;
    logic [N_SLV-1:0]   sel_n;
    logic               load, cap_rd;
    logic [N_SLV-1:0]   dec_sel;
    logic               dec_hit, dec_pol;
    logic [31:0]        sel_rd;
    logic               sel_ready;

    bridge_decode #(
        .N_SLV    (N_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_LIMIT(SLV_LIMIT),
        .SLV_RO   (SLV_RO),
        .SLV_WORD (SLV_WORD)
    ) u_decode (
        .addr      (pr_addr),
        .byteen    (pr_byteen),
        .sel       (dec_sel),
        .hit       (dec_hit),
        .policy_err(dec_pol)
    );

    always_comb begin
        sel_rd    = '0;
        sel_ready = 1'b0;
        for (int unsigned k = 0; k < N_SLV; k++) begin
            if (dev_sel[k]) begin
                sel_rd    = sel_rd | dev_rd[32*k +: 32];
                sel_ready = sel_ready | dev_ready[k];
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        code_n  = pr_err_code;
        sel_n   = dev_sel;
        load    = 1'b0;
        cap_rd  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pr_req && (pr_rd_en || (|pr_byteen))) begin
                    load  = 1'b1;
                    cnt_n = '0;
                    if (!dec_hit) begin
                        state_n = ST_RESP;
                        code_n  = ERR_UNMAP;
                    end else if (dec_pol || (pr_rd_en && (|pr_byteen))) begin
                        state_n = ST_RESP;
                        code_n  = ERR_POLICY;
                    end else begin
                        state_n = ST_ACCESS;
                        code_n  = ERR_NONE;
                        sel_n   = dec_sel;
                    end
                end
            end
            ST_ACCESS: begin
                // ready is checked before the limit so a same-edge ready completes normally
                if (sel_ready) begin
                    state_n = ST_RESP;
                    code_n  = ERR_NONE;
                    sel_n   = '0;
                    cap_rd  = ~(|dev_byteen);
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_n = ST_RESP;
                    code_n  = ERR_TIMEOUT;
                    sel_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                sel_n   = '0;
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                sel_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pr_err_code <= ERR_NONE;
            pr_rd       <= '0;
            dev_sel     <= '0;
            dev_addr    <= '0;
            dev_wd      <= '0;
            dev_byteen  <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            pr_err_code <= code_n;
            dev_sel     <= sel_n;
            if (load) begin
                dev_addr   <= pr_addr;
                dev_wd     <= pr_wd;
                dev_byteen <= pr_byteen;
            end
            if (cap_rd)
                pr_rd <= sel_rd;
        end
    end

    assign pr_done = (state == ST_RESP);
    assign pr_err  = pr_done && (pr_err_code != ERR_NONE);
    assign pr_busy = (state != ST_IDLE);

endmodule
